// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hazard_state_e  - controller FSM states (RUN, MEM_WAIT, DRAIN, HALTED)
//   NOP_INSTR       - canonical NOP (addi x0,x0,0) loaded by pipeline
//                     registers on bubble/flush
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hazard_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
// Ports:
//   IF_ID_rs1/rs2          in  source registers of the ID instruction
//   IF_ID_use_rs1/use_rs2  in  ID instruction actually reads that source
//   ID_EX_rd               in  destination of the EX instruction
//   ID_EX_mem_read         in  EX instruction is a load
//   lu                     out load result needed by ID next cycle
module load_use_detect (
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic       IF_ID_use_rs1,
  input  logic       IF_ID_use_rs2,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_mem_read,
  output logic       lu
);

  logic hit_rs1;
  logic hit_rs2;

  always_comb begin
    hit_rs1 = IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd);
    hit_rs2 = IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd);
    // x0 is never written, so a load to x0 cannot create a dependency
    lu      = ID_EX_mem_read && (ID_EX_rd != 5'd0) && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RISC-V core.
// Handles load-use stalls, mispredict flushes, dmem wait freezes and the
// ECALL halt drain; owns the core halted flag.
// Optional feature macro: HAZARD_STALL_CNT_EN adds the stall_cycles port
// and counter (CNT_W bits, wrapping); control behaviour is unchanged.
// Ports:
//   clk, reset (async, active-high)
//   IF_ID_rs1/rs2, IF_ID_use_rs1/rs2, ID_EX_rd, ID_EX_mem_read : load-use inputs
//   mispredict, mem_req, dmem_ready, halt_req                   : event inputs
//   pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
//   ID_EX_flush, pipe_freeze, is_halted                        : controls
//   stall_cycles (macro only)                                   : stall counter
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4
`ifdef HAZARD_STALL_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic       IF_ID_use_rs1,
  input  logic       IF_ID_use_rs2,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_mem_read,
  input  logic       mispredict,
  input  logic       mem_req,
  input  logic       dmem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       ID_EX_bubble,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       pipe_freeze,
  output logic       is_halted
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

  hazard_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lu;
  logic          mem_stall;
  logic          eval_run;

  load_use_detect u_lu (
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2),
    .IF_ID_use_rs1  (IF_ID_use_rs1),
    .IF_ID_use_rs2  (IF_ID_use_rs2),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_mem_read (ID_EX_mem_read),
    .lu             (lu)
  );

  assign mem_stall = mem_req && !dmem_ready;

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    is_halted    = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    eval_run     = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_stall) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          pipe_freeze = 1'b1;
          state_nxt   = MEM_WAIT;
        end else begin
          eval_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          pipe_freeze = 1'b1;
        end else begin
          state_nxt = RUN;
          eval_run  = 1'b1;
        end
      end
      DRAIN: begin
        pc_write    = 1'b0;
        IF_ID_flush = 1'b1;
        if (mem_stall) begin
          // ECALL is frozen with the rest of the pipe; hold the count
          pipe_freeze = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = HALTED;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HALTED: begin
        is_halted   = 1'b1;
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    // Shared by RUN and the MEM_WAIT release cycle: events held during the
    // freeze are acted on here in priority order. A halt accepted on the
    // release cycle still enters DRAIN, otherwise the flushed ECALL is lost.
    if (eval_run) begin
      if (mispredict) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (lu) begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end else if (halt_req) begin
        pc_write    = 1'b0;
        IF_ID_flush = 1'b1;
        state_nxt   = DRAIN;
        cnt_nxt     = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_write && (state == RUN || state == MEM_WAIT)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Control outputs are compared as one packed vector:
//   {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush,
//    pipe_freeze, is_halted}
// With HAZARD_STALL_CNT_EN defined the counter is built 4 bits wide so the
// wrap can be reached by stalling.
module tb_hazard_ctrl;

  localparam logic [6:0] C_DEF    = 7'b1100000;
  localparam logic [6:0] C_LU     = 7'b0010000;
  localparam logic [6:0] C_FLUSH  = 7'b1101100;
  localparam logic [6:0] C_FREEZE = 7'b0000010;
  localparam logic [6:0] C_DRAIN  = 7'b0101000;
  localparam logic [6:0] C_DRFRZ  = 7'b0101010;
  localparam logic [6:0] C_HALT   = 7'b0001001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic       IF_ID_use_rs1, IF_ID_use_rs2, ID_EX_mem_read;
  logic       mispredict, mem_req, dmem_ready, halt_req;
  logic       pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush;
  logic       ID_EX_flush, pipe_freeze, is_halted;
  logic [6:0] ctl;
`ifdef HAZARD_STALL_CNT_EN
  logic [3:0] stall_cycles;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
                ID_EX_flush, pipe_freeze, is_halted};

  hazard_ctrl #(
    .DRAIN_CYCLES(4)
`ifdef HAZARD_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2),
    .IF_ID_use_rs1  (IF_ID_use_rs1),
    .IF_ID_use_rs2  (IF_ID_use_rs2),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_mem_read (ID_EX_mem_read),
    .mispredict     (mispredict),
    .mem_req        (mem_req),
    .dmem_ready     (dmem_ready),
    .halt_req       (halt_req),
    .pc_write       (pc_write),
    .IF_ID_write    (IF_ID_write),
    .ID_EX_bubble   (ID_EX_bubble),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_flush    (ID_EX_flush),
    .pipe_freeze    (pipe_freeze),
    .is_halted      (is_halted)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; ID_EX_rd = 5'd0;
    IF_ID_use_rs1 = 1'b0; IF_ID_use_rs2 = 1'b0; ID_EX_mem_read = 1'b0;
    mispredict = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1; halt_req = 1'b0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic set_lu();
    ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd5;
    IF_ID_rs1 = 5'd5; IF_ID_use_rs1 = 1'b1;
    IF_ID_rs2 = 5'd1; IF_ID_use_rs2 = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; idle();
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset();
    settle(); check("reset_ctl", 32'(ctl), 32'(C_DEF));
`ifdef HAZARD_STALL_CNT_EN
    check("reset_cnt", 32'(stall_cycles), 32'd0);
`endif

    // load-use: exactly one stall cycle, then defaults
    step(); set_lu();
    settle(); check("lu_stall", 32'(ctl), 32'(C_LU));
    step(); idle();
    settle(); check("lu_after", 32'(ctl), 32'(C_DEF));

    // no stall: load to x0
    step(); set_lu(); ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0;
    settle(); check("lu_rd0", 32'(ctl), 32'(C_DEF));
    // no stall: rs1 matches but not read
    step(); set_lu(); IF_ID_use_rs1 = 1'b0;
    settle(); check("lu_nouse", 32'(ctl), 32'(C_DEF));
    // rs2 dependency stalls
    step(); set_lu(); IF_ID_rs1 = 5'd2; IF_ID_rs2 = 5'd5;
    settle(); check("lu_rs2", 32'(ctl), 32'(C_LU));

    // mispredict beats load-use
    step(); set_lu(); mispredict = 1'b1;
    settle(); check("mp_over_lu", 32'(ctl), 32'(C_FLUSH));
    step(); idle();
    settle(); check("mp_after", 32'(ctl), 32'(C_DEF));

    // 3-cycle dmem wait with a held mispredict
    step(); mem_req = 1'b1; dmem_ready = 1'b0; mispredict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(); check($sformatf("mw_freeze%0d", i), 32'(ctl), 32'(C_FREEZE));
      step();
    end
    dmem_ready = 1'b1;
    settle(); check("mw_release", 32'(ctl), 32'(C_FLUSH));
    step(); idle();
    settle(); check("mw_after", 32'(ctl), 32'(C_DEF));

    // halt: accepted at edge N, is_halted after edge N+4
    do_reset();
    halt_req = 1'b1;
    settle(); check("halt_req", 32'(ctl), 32'(C_DRAIN));
    step(); halt_req = 1'b0; mispredict = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle(); check($sformatf("drain%0d", i), 32'(ctl), 32'(C_DRAIN));
      step();
    end
    settle(); check("halted", 32'(ctl), 32'(C_HALT));
    step(); idle(); set_lu();
    settle(); check("halted_hold", 32'(ctl), 32'(C_HALT));

    // reset mid-drain aborts to RUN at once
    do_reset();
    halt_req = 1'b1;
    step(); halt_req = 1'b0;
    step();
    settle(); check("drain_mid", 32'(ctl), 32'(C_DRAIN));
    reset = 1'b1; #1;
    check("rst_mid_drain", 32'(ctl), 32'(C_DEF));
    step(); reset = 1'b0;
    step(); step(); step(); step();
    settle(); check("rst_stays_run", 32'(ctl), 32'(C_DEF));

    // dmem wait during drain freezes and holds the count one cycle
    do_reset();
    halt_req = 1'b1;
    step(); halt_req = 1'b0; mem_req = 1'b1; dmem_ready = 1'b0;
    settle(); check("drain_freeze", 32'(ctl), 32'(C_DRFRZ));
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      settle(); check($sformatf("drainf%0d", i), 32'(ctl), 32'(C_DRAIN));
      step();
    end
    settle(); check("halted_late", 32'(ctl), 32'(C_HALT));

`ifdef HAZARD_STALL_CNT_EN
    // 1 load-use stall + 3 dmem wait cycles = 4
    do_reset();
    set_lu();
    step(); idle(); mem_req = 1'b1; dmem_ready = 1'b0;
    step(); step(); step(); dmem_ready = 1'b1;
    step(); idle();
    settle(); check("cnt_4", 32'(stall_cycles), 32'd4);
    // 12 more stalls: 16 wraps a 4-bit counter to 0
    set_lu();
    for (int i = 0; i < 12; i++) step();
    idle();
    settle(); check("cnt_wrap", 32'(stall_cycles), 32'd0);
    set_lu(); step(); idle();
    settle(); check("cnt_after_wrap", 32'(stall_cycles), 32'd1);
    // drain/halted cycles are not counted
    halt_req = 1'b1; step(); halt_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    settle(); check("cnt_no_drain", 32'(stall_cycles), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
